// File: rtl/joypad_pkg.sv
// +------------------------------------------------------------------+
// | joypad_pkg: button indices and debounce sizing for the joypad.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package joypad_pkg;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  localparam int NUM_BUTTONS             = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 33333;
  localparam int CNT_W                   = 16;

endpackage

`default_nettype wire

// File: rtl/joypad_responder_if.sv
// +------------------------------------------------------------------+
// | joypad_responder_if: raw buttons in, P1 row select / read-back.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface joypad_responder_if;
  logic [7:0] buttons;
  logic [1:0] joypad_sel;
  logic [3:0] joypad_data;
  logic       joypad_irq;
  logic [7:0] pressed;

  modport master (
    output buttons,
    output joypad_sel,
    input  joypad_data,
    input  joypad_irq,
    input  pressed
  );

  modport slave (
    input  buttons,
    input  joypad_sel,
    output joypad_data,
    output joypad_irq,
    output pressed
  );
endinterface

`default_nettype wire

// File: rtl/joypad_debounce.sv
// +------------------------------------------------------------------+
// | joypad_debounce: synchronizer plus stable-time debounce counter. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module joypad_debounce
  import joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  wire logic clock,
  input  wire logic reset_n,
  input  wire logic raw,
  output logic      clean
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   clean_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign clean  = clean_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any sample agreeing with the clean state throws away the whole count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else if (synced == clean_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= CNT_LAST) begin
      clean_q <= synced;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/joypad_responder.sv
// +------------------------------------------------------------------+
// | joypad_responder: debounced buttons muxed onto the DMG P1 port.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module joypad_responder
  import joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  joypad_responder_if.slave pad
);

  logic [NUM_BUTTONS-1:0] clean;
  logic [3:0]             dir_col;
  logic [3:0]             act_col;
  logic [3:0]             next_data;
  logic [3:0]             data_q;
  logic [3:0]             prev_data_q;
  logic                   irq_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    joypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (pad.buttons[i]),
      .clean   (clean[i])
    );
  end

  assign dir_col = ~clean[BTN_DOWN:BTN_RIGHT];
  assign act_col = ~clean[BTN_START:BTN_A];

  always_comb begin
    next_data = 4'hF;
    case (pad.joypad_sel)
      2'b11:   next_data = 4'hF;
      2'b10:   next_data = dir_col;
      2'b01:   next_data = act_col;
      default: next_data = dir_col & act_col;
    endcase
  end

  // irq looks at the registered port value, so row-select falls count too.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q      <= 4'hF;
      prev_data_q <= 4'hF;
      irq_q       <= 1'b0;
    end else begin
      data_q      <= next_data;
      prev_data_q <= data_q;
      irq_q       <= |(prev_data_q & ~data_q);
    end
  end

  assign pad.joypad_data = data_q;
  assign pad.joypad_irq  = irq_q;
  assign pad.pressed     = clean;

endmodule

`default_nettype wire
